// File: rtl/avalon_bus_master_pkg.sv
// Definitions shared by the Avalon bus master and the CPU load/store unit:
// transfer size encoding, master FSM states and the byte-lane enable map.
package avalon_bus_master_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    localparam int STALL_W = 8;
    typedef logic [STALL_W-1:0] stall_t;

    function automatic logic [3:0] lane_enable(input size_e size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic is_legal(input size_e size, input logic [1:0] offset);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~offset[0];
            SIZE_WORD: ok = (offset == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/avalon_bus_master_if.sv
// Avalon-MM bus between the master and a single slave.
interface avalon_bus_master_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );

endinterface

// File: rtl/avalon_bus_master_bus_lane_align.sv
// Byte-lane steering: store data shifted onto its lanes, load data pulled
// down to bit 0 and zero- or sign-extended.
module bus_lane_align
    import avalon_bus_master_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  byteenable,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        byteenable = lane_enable(size, offset);
        bus_wdata  = '0;
        load_data  = '0;
        rd_byte    = bus_rdata[{offset, 3'b000} +: 8];
        rd_half    = bus_rdata[{offset[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: begin
                bus_wdata = {24'b0, store_data[7:0]} << {offset, 3'b000};
                load_data = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            end
            SIZE_HALF: begin
                bus_wdata = {16'b0, store_data[15:0]} << {offset[1], 4'b0000};
                load_data = {{16{sign_ext & rd_half[15]}}, rd_half};
            end
            SIZE_WORD: begin
                bus_wdata = store_data;
                load_data = bus_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/avalon_bus_master.sv
// CPU load/store request to Avalon-MM master: one transfer at a time, with
// alignment checking, lane steering and a waitrequest stall timeout.
module avalon_bus_master
    import avalon_bus_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [31:0]                req_addr,
    input  logic [1:0]                 req_size,
    input  logic                       req_signed,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    avalon_bus_master_if.master        bus
);

    localparam stall_t TIMEOUT_C = stall_t'(TIMEOUT);

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        read_q, read_d, write_q, write_d;
    logic [31:0] address_q, address_d, writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    stall_t      stall_q, stall_d, stall_inc;
    size_e       size_q, size_d, req_size_e, align_size;
    logic        signed_q, signed_d;
    logic [1:0]  offset_q, offset_d, align_offset;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, load_data;

    assign req_size_e = size_e'(req_size);

    // In IDLE the aligner steers the incoming store; afterwards it extracts the load.
    assign align_size   = (state_q == IDLE) ? req_size_e : size_q;
    assign align_offset = (state_q == IDLE) ? req_addr[1:0] : offset_q;

    bus_lane_align u_align (
        .size       (align_size),
        .offset     (align_offset),
        .sign_ext   (signed_q),
        .store_data (req_wdata),
        .bus_rdata  (bus.readdata),
        .byteenable (lane_be),
        .bus_wdata  (lane_wdata),
        .load_data  (load_data)
    );

    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        byteenable_d = byteenable_q;
        writedata_d  = writedata_q;
        stall_d      = stall_q;
        size_d       = size_q;
        signed_d     = signed_q;
        offset_d     = offset_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;
        stall_inc    = stall_q + stall_t'(1);
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    size_d   = req_size_e;
                    signed_d = req_signed;
                    offset_d = req_addr[1:0];
                    if (is_legal(req_size_e, req_addr[1:0])) begin
                        address_d    = {req_addr[31:2], 2'b00};
                        byteenable_d = lane_be;
                        writedata_d  = req_write ? lane_wdata : '0;
                        read_d       = ~req_write;
                        write_d      = req_write;
                        stall_d      = '0;
                        state_d      = req_write ? WRITE : READ;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            READ, WRITE: begin
                if (!bus.waitrequest) begin
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (state_q == READ) ? load_data : '0;
                    state_d     = RESP;
                end else if (stall_inc >= TIMEOUT_C) begin
                    stall_d     = TIMEOUT_C;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    stall_d = stall_inc;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            byteenable_q <= '0;
            writedata_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            stall_q      <= '0;
            size_q       <= SIZE_BYTE;
            signed_q     <= 1'b0;
            offset_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            byteenable_q <= byteenable_d;
            writedata_q  <= writedata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            stall_q      <= stall_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            offset_q     <= offset_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign bus.address    = address_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.byteenable = byteenable_q;
    assign bus.writedata  = writedata_q;

endmodule

// File: tb/tb_avalon_bus_master.sv
// Directed bench for avalon_bus_master: a vector table of single transfers
// plus hand-written timeout and mid-transfer reset sequences.
module tb_avalon_bus_master;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam logic [31:0] JUNK = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[13];

    always #5 clk = ~clk;

    avalon_bus_master_if bus_if();

    avalon_bus_master #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bus        (bus_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts just after a negedge with the DUT idle; ends the same way.
    task automatic run_vec(input string tag, input vec_t v);
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = v.write;
        req_addr   = v.addr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_wdata  = v.wdata;
        bus_if.waitrequest = (v.waits != 0);
        bus_if.readdata    = (v.waits != 0) ? JUNK : v.rdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!v.exp_err) begin
            for (int c = 1; c <= v.waits + 1; c++) begin
                @(negedge clk);
                check($sformatf("%s cmd c%0d", tag, c), {30'b0, bus_if.read, bus_if.write},
                      v.write ? 32'd1 : 32'd2);
                check($sformatf("%s addr c%0d", tag, c), bus_if.address, v.exp_addr);
                check($sformatf("%s be c%0d", tag, c), {28'b0, bus_if.byteenable}, {28'b0, v.exp_be});
                if (v.write)
                    check($sformatf("%s wdata c%0d", tag, c), bus_if.writedata, v.exp_wdata);
                check($sformatf("%s early rsp c%0d", tag, c), {31'b0, rsp_valid}, 32'd0);
                @(posedge clk); #1;
                if (c == v.waits) begin
                    bus_if.waitrequest = 1'b0;
                    bus_if.readdata    = v.rdata;
                end
            end
        end
        @(negedge clk);
        check({tag, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, " rsp_err"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
        check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, " cmd idle"}, {30'b0, bus_if.read, bus_if.write}, 32'd0);
        @(negedge clk);
        check({tag, " rsp pulse end"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, " ready again"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        //            wr    addr          sz     sg    wdata          rdata          w  err   e_addr        e_be     e_wdata        e_rdata
        vecs[0]  = '{1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 32'h0000_0013, 2'b00, 1'b1, 32'h0,         32'h80FF_FF7F, 0, 1'b0, 32'h0000_0010, 4'b1000, 32'h0,         32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0,         32'h80FF_FF7F, 0, 1'b0, 32'h0000_0010, 4'b1000, 32'h0,         32'h0000_0080};
        vecs[3]  = '{1'b1, 32'h0000_0022, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0,         3, 1'b0, 32'h0000_0020, 4'b1100, 32'hABCD_0000, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0006, 2'b10, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0102, 2'b01, 1'b1, 32'h0,         32'h8001_7FFF, 1, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,         32'hFFFF_8001};
        vecs[6]  = '{1'b0, 32'h0000_0100, 2'b01, 1'b0, 32'h0,         32'h8001_F234, 0, 1'b0, 32'h0000_0100, 4'b0011, 32'h0,         32'h0000_F234};
        vecs[7]  = '{1'b1, 32'h0000_0045, 2'b00, 1'b0, 32'h1234_56A5, 32'h0,         0, 1'b0, 32'h0000_0044, 4'b0010, 32'h0000_A500, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0080, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0,         2, 1'b0, 32'h0000_0080, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 2'b11, 1'b0, 32'h0,         32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 32'h0000_0031, 2'b01, 1'b0, 32'h0000_1111, 32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 32'h0000_0011, 2'b00, 1'b1, 32'h0,         32'h0000_7F00, 0, 1'b0, 32'h0000_0010, 4'b0010, 32'h0,         32'h0000_007F};
        vecs[12] = '{1'b1, 32'h0000_0003, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0,         0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};

        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
        req_signed = 1'b0; req_wdata = '0;
        bus_if.waitrequest = 1'b0;
        bus_if.readdata    = '0;

        #2;
        check("reset ready", {31'b0, req_ready}, 32'd0);
        check("reset cmd", {30'b0, bus_if.read, bus_if.write}, 32'd0);
        check("reset addr", bus_if.address, 32'd0);
        check("reset be", {28'b0, bus_if.byteenable}, 32'd0);
        check("reset wdata", bus_if.writedata, 32'd0);
        check("reset rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
        check("reset rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            run_vec($sformatf("v%0d", i), vecs[i]);

        // Stall timeout: read held through exactly four stalled cycles.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040;
        req_size = 2'b10; req_signed = 1'b0;
        bus_if.waitrequest = 1'b1;
        bus_if.readdata    = JUNK;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("to read c%0d", c), {31'b0, bus_if.read}, 32'd1);
            check($sformatf("to early rsp c%0d", c), {31'b0, rsp_valid}, 32'd0);
        end
        @(negedge clk);
        check("to read drop", {31'b0, bus_if.read}, 32'd0);
        check("to rsp", {30'b0, rsp_valid, rsp_err}, 32'd3);
        check("to rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        check("to rsp end", {31'b0, rsp_valid}, 32'd0);
        bus_if.waitrequest = 1'b0;

        // Reset during a stalled read abandons it with no response.
        req_valid = 1'b1; req_addr = 32'h0000_0050;
        bus_if.waitrequest = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst read active", {31'b0, bus_if.read}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rst read async", {31'b0, bus_if.read}, 32'd0);
        check("rst addr async", bus_if.address, 32'd0);
        check("rst be async", {28'b0, bus_if.byteenable}, 32'd0);
        check("rst ready async", {31'b0, req_ready}, 32'd0);
        bus_if.waitrequest = 1'b0;
        bus_if.readdata    = JUNK;
        repeat (2) @(negedge clk);
        check("rst held rsp", {31'b0, rsp_valid}, 32'd0);
        check("rst held ready", {31'b0, req_ready}, 32'd0);
        reset = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("rst no rsp c%0d", c), {31'b0, rsp_valid}, 32'd0);
            check($sformatf("rst ready c%0d", c), {31'b0, req_ready}, 32'd1);
        end
        run_vec("post_rst", vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_bus_master.md
AVALON_BUS_MASTER -- requirements
Module: avalon_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 255: max consecutive waitrequest-stalled cycles before a transfer aborts with error.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces the Reset state immediately.
REQ-004 req_valid  input  1  CPU-side request present.
REQ-005 req_ready  output  1  block accepts a request this cycle (req_valid & req_ready = accept).
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word; 11 illegal.
REQ-009 req_signed  input  1  sign-extend byte/halfword loads.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  one-cycle pulse: transfer complete.
REQ-012 rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-013 rsp_err  output  1  qualified by rsp_valid: misalignment, illegal size or timeout.
REQ-014 address  output  32  Avalon word address, bits [1:0] always 0.
REQ-015 read, write  output  1 each  Avalon commands, never both high.
REQ-016 waitrequest  input  1  slave stall.
REQ-017 writedata  output  32  lane-shifted store data.
REQ-018 byteenable  output  4  active lanes.
REQ-019 readdata  input  32  valid in the cycle read=1 and waitrequest=0.

Function
REQ-020 FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-021 IDLE: accepted legal load -> READ; legal store -> WRITE; illegal request -> RESP with rsp_err=1, no bus command issued.
REQ-022 Illegal: req_size=11; halfword with req_addr[0]=1; word with req_addr[1:0]!=00.
REQ-023 Lanes little-endian: byte at offset k -> byteenable bit k, data bits [8k+7:8k]; halfword offset 0 -> 0011, offset 2 -> 1100; word -> 1111.
REQ-024 address, byteenable, writedata, read/write registered at accept and held constant while waitrequest=1.
REQ-025 READ/WRITE: transfer completes in first cycle with waitrequest=0; READ captures readdata that cycle; next state RESP.
REQ-026 Min latency: accept at edge N, command visible after N, completes at edge N+1 with zero wait, rsp_valid high after edge N+1 for exactly one cycle.
REQ-027 Stall counter (8 bits, saturating at TIMEOUT) increments per waitrequest=1 cycle; reaching TIMEOUT deasserts read/write, -> RESP with rsp_err=1.
REQ-028 RESP: rsp_valid=1 one cycle, then IDLE; next request accepted no earlier than the following cycle.
REQ-029 Load extraction: selected lane(s) shifted to bit 0; zero-extended, or sign-extended from bit 7/15 when req_signed=1.
REQ-030 Unused writedata lanes driven 0.

Reset
REQ-031 Reset low: state IDLE, read=0, write=0, address=0, byteenable=0, writedata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, stall counter=0, req_ready=0 while reset low, 1 from first cycle after release.
REQ-032 Reset mid-transfer abandons it: no rsp_valid is ever produced for it.

Structure
REQ-033 Shared package holds the size encoding (SIZE_BYTE/HALF/WORD), the FSM state enum and the lane-enable function shared with the CPU load/store unit.
REQ-034 One sub-module, bus_lane_align: combinational byteenable/writedata shifting and load extract/extend.

Verification
REQ-035 Word load addr 0x0000_0010, zero waits, readdata 0xDEADBEEF -> address 0x10, byteenable 1111, rsp_rdata 0xDEADBEEF, rsp_err 0, two cycles accept-to-rsp.
REQ-036 Signed byte load addr 0x13, readdata 0x80FF_FF7F -> byteenable 1000, rsp_rdata 0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-037 Halfword store addr 0x22, wdata 0x0000_ABCD, waitrequest high 3 cycles -> address 0x20, byteenable 1100, writedata 0xABCD_0000 held stable 4 cycles, write high exactly 4 cycles.
REQ-038 Word load addr 0x0000_0006 -> no read asserted, rsp_valid with rsp_err 1 one cycle after accept.
REQ-039 TIMEOUT=4, waitrequest stuck high -> read drops after 4 stalled cycles, rsp_err 1.
REQ-040 reset low during READ stall -> read=0 asynchronously, no rsp_valid, next request after release completes normally.
